// File: rtl/btn_debounce_pulse_pkg.sv
// Shared state encodings, bench timing defaults and the counter-width helper
// for the button conditioning slice.
package btn_debounce_pulse_pkg;

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam int TB_DEBOUNCE_CYCLES = 4;
    localparam int TB_REPEAT_DELAY    = 10;
    localparam int TB_REPEAT_PERIOD   = 3;

    // Wide enough to hold the largest of the three terminal counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit pin; 2-cycle latency.
// No backpressure: the synchronised level follows the pin continuously.
module sync_2ff
    import btn_debounce_pulse_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw push-button into one t_pulse per press, with optional auto-repeat.
// Press pulse lands DEBOUNCE_CYCLES+2 edges after the first 1 sample; no backpressure.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic t_pulse,
    output logic btn_level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             s2;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_nx;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_nx;
    logic             rep_phase;
    logic             phase_nx;
    logic             pulse_nx;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s2)
    );

    always_comb begin
        state_nx = state;
        deb_nx   = deb_cnt;
        rep_nx   = rep_cnt;
        phase_nx = rep_phase;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nx = PRESS_WAIT;
                    deb_nx   = '0;
                    rep_nx   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_nx = IDLE;
                    deb_nx   = '0;
                    rep_nx   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = PRESSED;
                    deb_nx   = '0;
                    rep_nx   = '0;
                    phase_nx = 1'b0;
                    pulse_nx = 1'b1;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nx = RELEASE_WAIT;
                    deb_nx   = '0;
                    rep_nx   = '0;
                end else if (REPEAT_EN) begin
                    // rep_phase = 0 waits the initial delay, 1 runs the repeat period.
                    if (rep_cnt == (rep_phase ? PER_LAST : DLY_LAST)) begin
                        rep_nx   = '0;
                        phase_nx = 1'b1;
                        pulse_nx = 1'b1;
                    end else begin
                        rep_nx = rep_cnt + 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_nx = PRESSED;
                    deb_nx   = '0;
                    rep_nx   = '0;
                    phase_nx = 1'b0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = IDLE;
                    deb_nx   = '0;
                    rep_nx   = '0;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            t_pulse   <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            state     <= state_nx;
            deb_cnt   <= deb_nx;
            rep_cnt   <= rep_nx;
            rep_phase <= phase_nx;
            t_pulse   <= pulse_nx;
            btn_level <= (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: one instance without and one with auto-repeat,
// both compared against a run-length reference model of the debounced level.
module tb_btn_debounce_pulse;
    import btn_debounce_pulse_pkg::*;

    localparam int D   = TB_DEBOUNCE_CYCLES;
    localparam int DLY = TB_REPEAT_DELAY;
    localparam int PER = TB_REPEAT_PERIOD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic t_pulse, btn_level, t_pulse_r, btn_level_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0),
                         .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .t_pulse(t_pulse), .btn_level(btn_level));

    btn_debounce_pulse #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1),
                         .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_r (
        .clk(clk), .rst(rst), .btn_in(btn_in), .t_pulse(t_pulse_r), .btn_level(btn_level_r));

    // Reference model: the level flips after D+1 consecutive disagreeing samples of
    // the pin seen two edges late; a repeat timer runs only while held with no bounce.
    bit   h1 = 1'b0, h2 = 1'b0;
    bit   m_lvl[2], m_first[2], m_pulse[2];
    int   m_run[2], m_since[2];
    logic [2:0] cnt = 3'b001;

    always @(posedge clk) begin
        bit s;
        s = h2;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_lvl[k] = 1'b0; m_run[k] = 0; m_since[k] = 0; m_first[k] = 1'b1; m_pulse[k] = 1'b0;
            end else begin
                m_pulse[k] = 1'b0;
                if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        m_lvl[k] = s;
                        m_run[k] = 0;
                        if (s) begin
                            m_pulse[k] = 1'b1; m_since[k] = 0; m_first[k] = 1'b1;
                        end
                    end
                end else if (m_run[k] != 0) begin
                    m_run[k] = 0;
                    if (m_lvl[k]) begin
                        m_since[k] = 0; m_first[k] = 1'b1;
                    end
                end else if (m_lvl[k] && k == 1) begin
                    m_since[k]++;
                    if (m_since[k] == (m_first[k] ? DLY : PER)) begin
                        m_pulse[k] = 1'b1; m_since[k] = 0; m_first[k] = 1'b0;
                    end
                end
            end
        end
        h2 = rst ? 1'b0 : h1;
        h1 = rst ? 1'b0 : btn_in;
        // 3-bit counter whose T input is the plain instance's t_pulse
        if (rst) cnt = 3'b001;
        else if (t_pulse) cnt = cnt + 3'd1;
    end

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (t_pulse !== 1'b0 || btn_level !== 1'b0) begin
            n_fail++; $display("FAIL reset_plain got pulse=%b level=%b exp 0 0", t_pulse, btn_level);
        end
        n_checks++;
        if (t_pulse_r !== 1'b0 || btn_level_r !== 1'b0) begin
            n_fail++; $display("FAIL reset_repeat got pulse=%b level=%b exp 0 0", t_pulse_r, btn_level_r);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (t_pulse !== 1'b0 || btn_level !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle got pulse=%b level=%b exp 0 0", t_pulse, btn_level);
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        settle(12);
        @(negedge clk);
        btn_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (t_pulse !== (i == 7)) begin
                n_fail++; $display("FAIL clean_press_pulse i=%0d got %b exp %b", i, t_pulse, i == 7);
            end
            n_checks++;
            if (btn_level !== (i >= 7)) begin
                n_fail++; $display("FAIL clean_press_level i=%0d got %b exp %b", i, btn_level, i >= 7);
            end
            if (t_pulse) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL clean_press_count got %0d exp 1", pulses);
        end
        btn_in = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level !== (j <= 6) || t_pulse !== 1'b0) begin
                n_fail++; $display("FAIL clean_release j=%0d got level=%b pulse=%b exp level=%b pulse=0",
                                   j, btn_level, t_pulse, j <= 6);
            end
        end
    endtask

    task automatic test_bounce_reject();
        bit pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        settle(12);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (t_pulse !== 1'b0 || btn_level !== 1'b0) begin
                n_fail++; $display("FAIL bounce_reject i=%0d got pulse=%b level=%b exp 0 0", i, t_pulse, btn_level);
            end
            btn_in = (i < 6) ? pat[i] : 1'b0;
        end
    endtask

    task automatic test_release_bounce();
        bit pat[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int pulses = 0;
        settle(12);
        @(negedge clk);
        btn_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (t_pulse) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL release_bounce_press got %0d pulses exp 1", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            btn_in = pat[i];
        end
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            n_checks++;
            if (t_pulse !== 1'b0 || btn_level !== (j <= 6)) begin
                n_fail++; $display("FAIL release_bounce j=%0d got pulse=%b level=%b exp pulse=0 level=%b",
                                   j, t_pulse, btn_level, j <= 6);
            end
            btn_in = 1'b0;
        end
    endtask

    task automatic test_auto_repeat();
        int pulses = 0;
        settle(12);
        @(negedge clk);
        btn_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (t_pulse_r !== (i == 7 || (i >= 17 && (i - 17) % PER == 0))) begin
                n_fail++; $display("FAIL auto_repeat_pulse i=%0d got %b", i, t_pulse_r);
            end
            n_checks++;
            if (t_pulse_r !== m_pulse[1] || t_pulse !== m_pulse[0]) begin
                n_fail++; $display("FAIL auto_repeat_model i=%0d got %b/%b exp %b/%b",
                                   i, t_pulse_r, t_pulse, m_pulse[1], m_pulse[0]);
            end
            if (t_pulse_r) pulses++;
        end
        n_checks++;
        if (pulses != 6) begin
            n_fail++; $display("FAIL auto_repeat_count got %0d exp 6", pulses);
        end
        btn_in = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            n_checks++;
            if (t_pulse_r !== (j == 2)) begin
                n_fail++; $display("FAIL auto_repeat_release j=%0d got %b exp %b", j, t_pulse_r, j == 2);
            end
        end
    endtask

    task automatic test_counter();
        @(negedge clk);
        rst = 1'b1;
        btn_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        settle(4);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                btn_in = 1'b1;
            end
            settle(12);
        end
        n_checks++;
        if (cnt !== 3'b110) begin
            n_fail++; $display("FAIL counter_presses got %b exp 110", cnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_in = 1'b1;
        end
        settle(12);
        n_checks++;
        if (cnt !== 3'b110) begin
            n_fail++; $display("FAIL counter_burst got %b exp 110", cnt);
        end
    endtask

    task automatic test_reset_mid_press();
        settle(12);
        @(negedge clk);
        btn_in = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (t_pulse !== 1'b0 || btn_level !== 1'b0 || btn_level_r !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset got pulse=%b level=%b level_r=%b exp 0 0 0",
                               t_pulse, btn_level, btn_level_r);
        end
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (t_pulse !== (i == 7) || btn_level !== (i >= 7)) begin
                n_fail++; $display("FAIL mid_reset_repress i=%0d got pulse=%b level=%b exp %b %b",
                                   i, t_pulse, btn_level, i == 7, i >= 7);
            end
        end
    endtask

    task automatic test_random();
        int left = 0;
        bit lvl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (t_pulse !== m_pulse[0] || btn_level !== m_lvl[0] ||
                t_pulse_r !== m_pulse[1] || btn_level_r !== m_lvl[1]) begin
                n_fail++; $display("FAIL random c=%0d got %b%b/%b%b exp %b%b/%b%b", c,
                                   t_pulse, btn_level, t_pulse_r, btn_level_r,
                                   m_pulse[0], m_lvl[0], m_pulse[1], m_lvl[1]);
            end
            if (left == 0) begin
                lvl  = ~lvl;
                left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 25));
            end
            left--;
            btn_in = lvl;
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_release_bounce();
        test_auto_repeat();
        test_counter();
        test_reset_mid_press();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
Conditions a raw, bouncing push-button input into the clean count-enable that the 3-bit counter consumes on its T input.
- Synchronises the asynchronous pin to clk.
- Debounces it with a stable-sample FSM.
- Emits exactly one single-cycle t_pulse per confirmed press.
- Optional auto-repeat: while the button is held, further pulses are issued at a fixed rate.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (D); must be >= 2. Bench uses 4.
- REPEAT_EN, 0, 1 enables auto-repeat pulses while held; 0 gives one pulse per press only.
- REPEAT_DELAY, 50000000, cycles from the press pulse to the first repeat pulse; must be >= 2.
- REPEAT_PERIOD, 10000000, cycles between later repeat pulses; must be >= 2.

Ports:
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous reset, active-high
- btn_in  input  1  raw button level, asynchronous, bouncing, 1 = pressed
- t_pulse  output  1  one-cycle enable pulse; drives the counter's T input
- btn_level  output  1  debounced button level, registered

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - sync flops s1 and s2 = 0
  - state = IDLE
  - deb_cnt and rep_cnt = 0
  - t_pulse = 0, btn_level = 0
  - Reset wins over every other event on the same edge.
- Synchroniser: 2-flop chain (s1 <= btn_in, s2 <= s1). The FSM uses only s2; btn_in drives nothing else.
- Counter widths: CNT_W = clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1). Counters never wrap; each is cleared on every state change.
- IDLE:
  - s2 = 1 -> PRESS_WAIT, deb_cnt <= 0.
- PRESS_WAIT:
  - s2 = 0 -> IDLE (bounce rejected, no pulse).
  - s2 = 1 and deb_cnt < D-1 -> deb_cnt++.
  - s2 = 1 and deb_cnt == D-1 -> PRESSED, t_pulse <= 1 for exactly one cycle, rep_cnt <= 0.
- PRESSED:
  - s2 = 0 -> RELEASE_WAIT, deb_cnt <= 0.
  - Otherwise, if REPEAT_EN: rep_cnt counts every cycle.
    - First repeat pulse fires REPEAT_DELAY cycles after the press pulse.
    - Later repeat pulses fire every REPEAT_PERIOD cycles.
    - rep_cnt clears on each pulse; a one-bit flag selects DELAY vs PERIOD.
- RELEASE_WAIT:
  - s2 = 1 -> PRESSED. No pulse; rep_cnt <= 0 and the DELAY phase restarts.
  - s2 = 0 and deb_cnt == D-1 -> IDLE.
  - Otherwise deb_cnt++.
- btn_level: 1 in PRESSED and RELEASE_WAIT, 0 otherwise; registered with the state.
- Press latency: let E0 be the first edge that samples btn_in = 1. If btn_in is 1 at edges E0..E0+D, t_pulse is high in the cycle after edge E0+D+2. Any 0 sample in that window -> no pulse, and the count restarts from IDLE.
- Release: btn_in must be 0 for D+1 consecutive samples before a new press can be accepted.
- Pulse rules:
  - t_pulse is never high on two consecutive cycles, since REPEAT_PERIOD >= 2.
  - t_pulse is never high in IDLE, PRESS_WAIT or RELEASE_WAIT after their entry edge.
- Reset mid-press: the flops clear, so a button still held after rst deasserts is treated as a new press and gets a full debounce and one pulse.

Decomposition:
- Shared package holds:
  - state enum: IDLE = 2'd0, PRESS_WAIT = 2'd1, PRESSED = 2'd2, RELEASE_WAIT = 2'd3
  - default bench timing constants: D = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3
- Sub-module sync_2ff (clk, rst, d, q) for the synchroniser; it is reused for other pins.
- FSM and counters stay in btn_debounce_pulse.

Test Plan:
All scenarios use D = 4.
- Clean press: btn_in 0 -> 1 held 20 cycles -> exactly one t_pulse, high in the cycle after edge E0+6; btn_level rises on that edge and stays 1 until release_wait completes.
- Bounce reject: btn_in pattern 1,1,0,1,1,0 then 0 -> t_pulse never asserts; state returns to IDLE; btn_level stays 0.
- Release bounce: press confirmed, then btn_in 0,0,1,1 then 0 held -> no second pulse; btn_level falls only after 5 consecutive 0 samples.
- Auto-repeat (REPEAT_EN = 1, REPEAT_DELAY = 10, REPEAT_PERIOD = 3), hold 30 cycles -> pulses at P, P+10, P+13, P+16, ...; all stop once RELEASE_WAIT is entered.
- Counter integration: drive the counter's T from t_pulse, counter starting at 001, with 5 clean presses -> counter reads 110; a 4-cycle bounce burst adds nothing.
- Reset mid-press: rst high for 1 cycle while PRESSED with btn_in held -> t_pulse and btn_level are 0 the next cycle; one new pulse follows E0+6 after reset release.
